// File: rtl/eps_pkg.sv
// rtl/eps_pkg.sv - shared state encoding and widths for the epsilon scheduler
package eps_pkg;
  typedef enum logic [1:0] {IDLE, SEED, WARM, RUN} state_e;
  localparam int SEED_W = 5;
  localparam int CNT_W  = 16;
endpackage

// File: rtl/eps_sched_rr_arbiter.sv
// rtl/eps_sched_rr_arbiter.sv - combinational round-robin arbiter, search begins at ptr
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] win,
  output logic          any
);
  logic          found;
  logic [IW-1:0] idx;
  int            sum;

  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    sum   = 0;
    for (int off = 0; off < N; off++) begin
      sum = (int'(ptr) + off) % N;
      idx = IW'(sum);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        win      = idx;
        found    = 1'b1;
      end
    end
  end

  assign any = |req;
endmodule

// File: rtl/eps_sched.sv
// rtl/eps_sched.sv - round-robin epsilon PRNG scheduler with seed/warm-up sequencing; EPS_SIGN_EN adds sign alternation
module eps_sched
  import eps_pkg::*;
#(
  parameter int BITSIZE   = 20,
  parameter int N_REQ     = 4,
  parameter int SEED_CYC  = 2,
  parameter int WARMUP    = 2,
  parameter int EPOCH_LEN = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [SEED_W-1:0]  seed_in,
  input  logic               reseed,
  input  logic [N_REQ-1:0]   req,
  output logic [N_REQ-1:0]   gnt,
  output logic [BITSIZE-1:0] eps_data,
  output logic               eps_valid,
  output logic               busy,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic               prng_rst,
  output logic [SEED_W-1:0]  prng_seed,
  input  logic [BITSIZE-1:0] prng_data
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [BITSIZE-1:0] eps_q, eps_d;
  logic               vld_q, vld_d;
  logic [SEED_W-1:0]  seed_q, seed_d;
  logic               sign_q, sign_d;
  logic [BITSIZE-1:0] sample;

  logic [N_REQ-1:0]   arb_gnt;
  logic [PW-1:0]      arb_win;
  logic               arb_any;

  rr_arbiter #(.N(N_REQ), .IW(PW)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .win (arb_win),
    .any (arb_any)
  );

`ifdef EPS_SIGN_EN
  assign sample = sign_q ? (BITSIZE'(0) - prng_data) : prng_data;
`else
  assign sample = prng_data;
`endif

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    vld_d   = 1'b0;
    eps_d   = eps_q;
    seed_d  = seed_q;
    sign_d  = sign_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEED;
          seed_d  = seed_in;
          cyc_d   = '0;
          cnt_d   = '0;
          sign_d  = 1'b0;
        end
      end
      SEED: begin
        if (cyc_q == CNT_W'(SEED_CYC - 1)) begin
          state_d = WARM;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      WARM: begin
        if (cyc_q == CNT_W'(WARMUP - 1)) begin
          state_d = RUN;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      RUN: begin
        // Reseed takes priority over the epoch limit and any pending request
        if (reseed || (EPOCH_LEN != 0 && cnt_q == CNT_W'(EPOCH_LEN))) begin
          state_d = SEED;
          seed_d  = reseed ? seed_in : seed_q + 1'b1;
          cyc_d   = '0;
          cnt_d   = '0;
          sign_d  = 1'b0;
        end else if (arb_any) begin
          gnt_d  = arb_gnt;
          vld_d  = 1'b1;
          eps_d  = sample;
          cnt_d  = cnt_q + 1'b1;
          ptr_d  = (arb_win == PW'(N_REQ - 1)) ? '0 : arb_win + 1'b1;
          sign_d = ~sign_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      eps_q   <= '0;
      vld_q   <= 1'b0;
      seed_q  <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      eps_q   <= eps_d;
      vld_q   <= vld_d;
      seed_q  <= seed_d;
    end
  end

`ifdef EPS_SIGN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sign_q <= 1'b0;
    else        sign_q <= sign_d;
  end
`else
  assign sign_q = 1'b0;
  logic unused_sign;
  assign unused_sign = sign_d;
`endif

  assign gnt        = gnt_q;
  assign eps_valid  = vld_q;
  assign eps_data   = eps_q;
  assign busy       = (state_q == SEED) || (state_q == WARM);
  assign prng_rst   = (state_q == IDLE) || (state_q == SEED);
  assign prng_seed  = seed_q;
  assign sample_cnt = cnt_q;
endmodule

// File: tb/tb_eps_sched.sv
// tb/tb_eps_sched.sv - self-checking bench for eps_sched: vector table, scoreboard, corner sequences
module tb_eps_sched;
  logic        clk, rst_n;
  logic        start_a, reseed_a, start_b, reseed_b;
  logic [4:0]  seed_a, seed_b;
  logic [3:0]  req_a, req_b;
  logic [19:0] prng_a, prng_b;
  logic [3:0]  gnt_a, gnt_b;
  logic [19:0] eps_a, eps_b;
  logic        vld_a, vld_b, busy_a, busy_b, prst_a, prst_b;
  logic [15:0] cnt_a, cnt_b;
  logic [4:0]  pseed_a, pseed_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  gnt;
    logic        vld;
    logic [19:0] data;
    logic [15:0] cnt;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [15:0] cnt;
  } vec_t;
  vec_t tbl[16];

  logic [19:0] last_d;
  logic        sign_m;

  eps_sched #(.BITSIZE(20), .N_REQ(4), .SEED_CYC(2), .WARMUP(2), .EPOCH_LEN(64)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .seed_in(seed_a), .reseed(reseed_a),
    .req(req_a), .gnt(gnt_a), .eps_data(eps_a), .eps_valid(vld_a), .busy(busy_a),
    .sample_cnt(cnt_a), .prng_rst(prst_a), .prng_seed(pseed_a), .prng_data(prng_a)
  );

  eps_sched #(.BITSIZE(20), .N_REQ(4), .SEED_CYC(2), .WARMUP(2), .EPOCH_LEN(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .seed_in(seed_b), .reseed(reseed_b),
    .req(req_b), .gnt(gnt_b), .eps_data(eps_b), .eps_valid(vld_b), .busy(busy_b),
    .sample_cnt(cnt_b), .prng_rst(prst_b), .prng_seed(pseed_b), .prng_data(prng_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_cycle(input logic [3:0] r, input logic [3:0] eg,
                          input logic [15:0] ec, input logic [19:0] p);
    exp_t e;
    req_a  = r;
    prng_a = p;
    if (eg != 4'd0) begin
`ifdef EPS_SIGN_EN
      last_d = sign_m ? (20'd0 - p) : p;
      sign_m = ~sign_m;
`else
      last_d = p;
`endif
    end
    e.gnt = eg; e.vld = (eg != 4'd0); e.data = last_d; e.cnt = ec;
    sbq.push_back(e);
    step();
    e = sbq.pop_front();
    check("gnt", 32'(gnt_a), 32'(e.gnt));
    check("eps_valid", 32'(vld_a), 32'(e.vld));
    check("eps_data", 32'(eps_a), 32'(e.data));
    check("sample_cnt", 32'(cnt_a), 32'(e.cnt));
  endtask

  initial begin
    logic [4:0] exp_prst;
    logic [4:0] exp_busy;
    exp_prst = 5'b00011;
    exp_busy = 5'b01111;

    tbl[0]  = '{4'b1111, 4'b0001, 16'd1};
    tbl[1]  = '{4'b1111, 4'b0010, 16'd2};
    tbl[2]  = '{4'b1111, 4'b0100, 16'd3};
    tbl[3]  = '{4'b1111, 4'b1000, 16'd4};
    tbl[4]  = '{4'b1111, 4'b0001, 16'd5};
    tbl[5]  = '{4'b1111, 4'b0010, 16'd6};
    tbl[6]  = '{4'b1111, 4'b0100, 16'd7};
    tbl[7]  = '{4'b1111, 4'b1000, 16'd8};
    tbl[8]  = '{4'b0100, 4'b0100, 16'd9};
    tbl[9]  = '{4'b0100, 4'b0100, 16'd10};
    tbl[10] = '{4'b0000, 4'b0000, 16'd10};
    tbl[11] = '{4'b0011, 4'b0001, 16'd11};
    tbl[12] = '{4'b0011, 4'b0010, 16'd12};
    tbl[13] = '{4'b1001, 4'b1000, 16'd13};
    tbl[14] = '{4'b1001, 4'b0001, 16'd14};
    tbl[15] = '{4'b1010, 4'b0010, 16'd15};

    last_d = '0; sign_m = 1'b0;
    rst_n = 1'b0;
    start_a = 0; reseed_a = 0; seed_a = 0; req_a = 0; prng_a = 0;
    start_b = 0; reseed_b = 0; seed_b = 0; req_b = 0; prng_b = 0;
    #3;
    check("rst gnt", 32'(gnt_a), 0);
    check("rst eps_valid", 32'(vld_a), 0);
    check("rst eps_data", 32'(eps_a), 0);
    check("rst busy", 32'(busy_a), 0);
    check("rst sample_cnt", 32'(cnt_a), 0);
    check("rst prng_rst", 32'(prst_a), 1);
    check("rst prng_seed", 32'(pseed_a), 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Epoch auto-reseed on the EPOCH_LEN=4 instance
    start_b = 1; seed_b = 5'd31; req_b = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      prng_b = 20'($urandom);
      step();
      start_b = 0;
      check("b startup gnt", 32'(gnt_b), 0);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      check("b epoch gnt", 32'(gnt_b), 32'(1 << k));
      check("b epoch cnt", 32'(cnt_b), 32'(k + 1));
    end
    step();
    check("b epoch busy", 32'(busy_b), 1);
    check("b epoch gnt0", 32'(gnt_b), 0);
    check("b epoch seed wrap", 32'(pseed_b), 0);
    check("b epoch cnt0", 32'(cnt_b), 0);
    check("b epoch prng_rst", 32'(prst_b), 1);
    req_b = 0;

    // Startup of A with requests pending: no grant while sequencing
    start_a = 1; seed_a = 5'd5; req_a = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      prng_a = 20'($urandom);
      step();
      start_a = 0;
      check("start prng_rst", 32'(prst_a), 32'(exp_prst[i]));
      check("start busy", 32'(busy_a), 32'(exp_busy[i]));
      check("start gnt", 32'(gnt_a), 0);
      check("start seed", 32'(pseed_a), 5);
    end

    for (int i = 0; i < 16; i++)
      sb_cycle(tbl[i].req, tbl[i].gnt, tbl[i].cnt, 20'($urandom));

    // start while running is ignored
    start_a = 1; seed_a = 5'd7;
    sb_cycle(4'b1111, 4'b0100, 16'd16, 20'($urandom));
    start_a = 0;
    check("start in run seed", 32'(pseed_a), 5);

    // reseed colliding with req: reseed wins
    seed_a = 5'd9; reseed_a = 1; req_a = 4'b1111;
    step();
    reseed_a = 0;
    sign_m = 1'b0;
    check("reseed gnt", 32'(gnt_a), 0);
    check("reseed eps_valid", 32'(vld_a), 0);
    check("reseed busy", 32'(busy_a), 1);
    check("reseed seed", 32'(pseed_a), 9);
    check("reseed cnt", 32'(cnt_a), 0);
    check("reseed eps_data hold", 32'(eps_a), 32'(last_d));
    for (int i = 0; i < 4; i++) begin
      step();
      check("reseed wait gnt", 32'(gnt_a), 0);
      check("reseed wait busy", 32'(busy_a), 32'(exp_busy[i + 1]));
    end
    sb_cycle(4'b1111, 4'b1000, 16'd1, 20'($urandom));

    // constant PRNG word: symmetric stream when sign feature is built in
    for (int i = 0; i < 4; i++)
      sb_cycle(4'b0100, 4'b0100, 16'(i + 2), 20'h00E38);

    // asynchronous reset in the middle of a grant
    sb_cycle(4'b1111, 4'b1000, 16'd6, 20'($urandom));
    #2 rst_n = 1'b0;
    #1;
    check("midrst gnt", 32'(gnt_a), 0);
    check("midrst eps_valid", 32'(vld_a), 0);
    check("midrst eps_data", 32'(eps_a), 0);
    check("midrst cnt", 32'(cnt_a), 0);
    check("midrst prng_rst", 32'(prst_a), 1);
    check("midrst seed", 32'(pseed_a), 0);
    check("midrst busy", 32'(busy_a), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
